// File: rtl/daq_pkg.sv
// Shared DAQ definitions: sample/timestamp widths, header length and the
// capture FSM state encoding.
package daq_pkg;

    localparam int DATA_W    = 16;
    localparam int TS_W      = 32;
    localparam int HDR_WORDS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2
    } state_t;

endpackage

// File: rtl/ring_buffer.sv
// Simple dual-port sample ring: synchronous write, synchronous read,
// array deliberately left without reset.
module ring_buffer #(
    parameter int AW     = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/event_capture.sv
// Pre/post-trigger frame capture with timestamped valid/ready readout.
// Holds the FSM, ring pointers, timestamp, edge detect and output register.
module event_capture #(
    parameter int DATA_W = daq_pkg::DATA_W,
    parameter int PRE    = 4,
    parameter int POST   = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              trigger_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              trig_dropped,
    output logic [1:0]        state_dbg
);

    import daq_pkg::*;

    localparam int N_WORDS = HDR_WORDS + PRE + POST;
    localparam int CNT_W   = $clog2(N_WORDS + 1);

    state_t            state, state_next;
    logic [TS_W-1:0]   ts, ts_lat;
    logic              trig_d, trig_edge, armed;
    logic [AW:0]       fill;
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_next, post_cnt;
    logic [CNT_W-1:0]  word_cnt;
    logic              ram_we, load, final_write, last_accept;
    logic [DATA_W-1:0] ram_q, load_data;

    assign trig_edge   = trigger_in & ~trig_d;
    assign armed       = (fill == (AW+1)'(PRE));
    assign last_accept = out_valid & out_ready & out_last;
    assign final_write = ((state == CAPTURE) && (post_cnt == AW'(POST - 1))) ||
                         ((state == IDLE) && trig_edge && armed && (POST == 1));
    assign state_dbg   = state;

    ring_buffer #(.AW(AW), .DATA_W(DATA_W)) u_ring (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr_next),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trig_edge && armed) state_next = (POST == 1) ? READOUT : CAPTURE;
            CAPTURE: if (final_write) state_next = READOUT;
            READOUT: if (last_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake: a word is transferred on a cycle where out_valid & out_ready.
    // out_valid is registered; once raised, out_data/out_last hold until accepted.
    // The RAM is addressed with the *next* read pointer, so its output register
    // always holds mem[rd_ptr] and acts as the prefetch stage.
    always_comb begin
        busy         = (state != IDLE);
        trig_dropped = ~rst & trig_edge & ((state != IDLE) | ~armed);
        ram_we       = (state != READOUT);
        load         = (state == READOUT) && (word_cnt < CNT_W'(N_WORDS)) &&
                       (!out_valid || out_ready);
        load_data    = ram_q;
        if (word_cnt == CNT_W'(0)) begin
            load_data = DATA_W'(ts_lat[TS_W-1:TS_W/2]);
        end else if (word_cnt == CNT_W'(1)) begin
            load_data = DATA_W'(ts_lat[TS_W/2-1:0]);
        end
        rd_ptr_next = rd_ptr;
        if (final_write) begin
            rd_ptr_next = wr_ptr - AW'(PRE + POST - 1);
        end else if (load && (word_cnt >= CNT_W'(HDR_WORDS))) begin
            rd_ptr_next = rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts        <= '0;
            ts_lat    <= '0;
            trig_d    <= 1'b0;
            fill      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            ts     <= ts + TS_W'(1);
            trig_d <= trigger_in;
            rd_ptr <= rd_ptr_next;
            if (ram_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (!armed) begin
                        fill <= fill + (AW+1)'(1);
                    end
                    if (trig_edge && armed) begin
                        ts_lat   <= ts;
                        post_cnt <= AW'(1);
                        word_cnt <= '0;
                    end
                end
                CAPTURE: post_cnt <= post_cnt + AW'(1);
                READOUT: begin
                    if (load) begin
                        out_valid <= 1'b1;
                        out_data  <= load_data;
                        out_last  <= (word_cnt == CNT_W'(N_WORDS - 1));
                        word_cnt  <= word_cnt + CNT_W'(1);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    // History is rebuilt from scratch after every frame.
                    if (last_accept) begin
                        fill <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_event_capture.sv
// Self-checking bench for event_capture: ramp stimulus, expected frame words
// queued when a trigger is driven and compared as the DUT presents them.
module tb_event_capture;

    localparam int DW   = 16;
    localparam int PRE  = 4;
    localparam int POST = 8;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          trigger_in = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          trig_dropped;
    logic [1:0]    state_dbg;

    logic [DW:0]   exp_q[$];
    int            n_vec = 0;
    int            n_miss = 0;
    int            cyc = 0;
    int            ready_mode = 0;
    int            drop_cnt = 0;
    int            exp_drops = 0;
    int            acc_cnt = 0;

    event_capture #(.DATA_W(DW), .PRE(PRE), .POST(POST), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .trigger_in   (trigger_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .trig_dropped (trig_dropped),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        data_in = cyc[DW-1:0];
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = cyc[0];
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        trigger_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
        data_in = '0;
        acc_cnt = 0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push_frame(input int t);
        logic [31:0] ts_val;
        ts_val = 32'(t);
        exp_q.push_back({1'b0, ts_val[31:16]});
        exp_q.push_back({1'b0, ts_val[15:0]});
        for (int k = t - PRE; k < t + POST; k++) begin
            exp_q.push_back({(k == t + POST - 1), DW'(k)});
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        check("frame_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    // scoreboard: every presented word is compared with the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (trig_dropped) drop_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {16'd0, out_data}, 32'hdead);
                end else begin
                    check("word_data", 32'(out_data), 32'(exp_q[0][DW-1:0]));
                    check("word_last", 32'(out_last), 32'(exp_q[0][DW]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int t2;

        // reset state
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(trig_dropped), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // basic frame, ready held high
        ready_mode = 0;
        run_to(20);
        trigger_in = 1'b1;
        push_frame(20);
        tick();
        check("busy_rise", 32'(busy), 32'd1);
        trigger_in = 1'b0;
        run_to(20 + POST + 2);
        check("hdr_latency", 32'(out_valid), 32'd1);
        wait_frame();

        // same trigger with toggling ready
        do_reset();
        ready_mode = 1;
        run_to(20);
        trigger_in = 1'b1;
        push_frame(20);
        tick();
        trigger_in = 1'b0;
        wait_frame();

        // trigger before the history is full
        do_reset();
        ready_mode = 0;
        run_to(2);
        trigger_in = 1'b1;
        exp_drops++;
        tick();
        trigger_in = 1'b0;
        repeat (15) tick();
        check("early_no_busy", 32'(busy), 32'd0);
        check("early_drops", 32'(drop_cnt), 32'(exp_drops));

        // edges during CAPTURE and READOUT are dropped
        do_reset();
        ready_mode = 2;
        run_to(20);
        trigger_in = 1'b1;
        push_frame(20);
        tick();
        trigger_in = 1'b0;
        run_to(23);
        trigger_in = 1'b1;
        exp_drops++;
        tick();
        trigger_in = 1'b0;
        run_to(31);
        trigger_in = 1'b1;
        exp_drops++;
        tick();
        trigger_in = 1'b0;
        wait_frame();
        check("busy_drops", 32'(drop_cnt), 32'(exp_drops));

        // trigger held across frame end needs a fresh edge
        do_reset();
        ready_mode = 0;
        run_to(20);
        trigger_in = 1'b1;
        push_frame(20);
        wait_frame();
        repeat (3) tick();
        check("held_no_retrig", 32'(busy), 32'd0);
        trigger_in = 1'b0;
        repeat (10) tick();
        t2 = cyc;
        trigger_in = 1'b1;
        push_frame(t2);
        tick();
        trigger_in = 1'b0;
        wait_frame();
        check("held_drops", 32'(drop_cnt), 32'(exp_drops));

        // reset mid-frame, then a fresh frame
        do_reset();
        ready_mode = 0;
        run_to(20);
        trigger_in = 1'b1;
        push_frame(20);
        tick();
        trigger_in = 1'b0;
        n = 0;
        while (acc_cnt < 5 && n < 100) begin
            tick();
            n++;
        end
        check("five_accepted", 32'(acc_cnt >= 5), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_last", 32'(out_last), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        exp_q.delete();
        do_reset();
        ready_mode = 2;
        run_to(25);
        trigger_in = 1'b1;
        push_frame(25);
        tick();
        trigger_in = 1'b0;
        wait_frame();
        check("final_drops", 32'(drop_cnt), 32'(exp_drops));

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
